// File: rtl/n8_pkg.sv
// n8_pkg: shared N8 protocol constants, button index order and responder state type
package n8_pkg;
    localparam int N8_BITS   = 8;
    localparam int BTN_A     = 0;
    localparam int BTN_B     = 1;
    localparam int BTN_SEL   = 2;
    localparam int BTN_START = 3;
    localparam int BTN_UP    = 4;
    localparam int BTN_DOWN  = 5;
    localparam int BTN_LEFT  = 6;
    localparam int BTN_RIGHT = 7;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} n8_resp_state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-stage synchronizer for an asynchronous level with registered level/rise/fall
//   clk, reset_n (async active-low) | sig: async input | level, rise, fall: registered outputs
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], sig};
            level <= sync[SYNC_STAGES-1];
            rise  <= sync[SYNC_STAGES-1] & ~level;
            fall  <= ~sync[SYNC_STAGES-1] & level;
        end
    end
endmodule

// File: rtl/n8_responder.sv
// n8_responder: controller-side N8 gamepad emulator (parallel-in, serial-out, active-low data)
//   clk, reset_n (async active-low) | latch, pulse: async host strobes | buttons: 1 = pressed
//   data: registered serial line | bit_idx: bit on data (8 = past end) | frame_done: strobe | overrun: sticky
module n8_responder
    import n8_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int N_BITS      = N8_BITS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              latch,
    input  logic              pulse,
    input  logic [N_BITS-1:0] buttons,
    output logic              data,
    output logic [3:0]        bit_idx,
    output logic              frame_done,
    output logic              overrun
);
    n8_resp_state_t    state;
    logic [N_BITS-1:0] shreg;
    logic latch_lvl, latch_rise, latch_fall;
    logic pulse_lvl, pulse_rise, pulse_fall;
    logic last;
    logic unused_edges;
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch (
        .clk(clk), .reset_n(reset_n), .sig(latch),
        .level(latch_lvl), .rise(latch_rise), .fall(latch_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse (
        .clk(clk), .reset_n(reset_n), .sig(pulse),
        .level(pulse_lvl), .rise(pulse_rise), .fall(pulse_fall)
    );
    assign unused_edges = &{latch_lvl, pulse_lvl, pulse_fall};
    assign last = bit_idx == 4'(N_BITS - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '1;
            data       <= 1'b1;
            bit_idx    <= 4'd0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // a latch rise restarts the frame from any state and swallows a coincident pulse
            if (latch_rise) begin
                state   <= LOAD;
                shreg   <= ~buttons;
                data    <= ~buttons[0];
                bit_idx <= 4'd0;
                overrun <= 1'b0;
            end else begin
                case (state)
                    IDLE: data <= 1'b1;
                    // transparent while latch is held; the final LOAD cycle's capture is the frame
                    LOAD: begin
                        shreg <= ~buttons;
                        data  <= ~buttons[0];
                        if (latch_fall) state <= SHIFT;
                    end
                    SHIFT: if (pulse_rise) begin
                        shreg   <= {1'b1, shreg[N_BITS-1:1]};
                        data    <= last ? 1'b1 : shreg[1];
                        bit_idx <= bit_idx + 4'd1;
                        if (last) begin
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end
                    end
                    DONE: begin
                        data <= 1'b1;
                        if (pulse_rise) overrun <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_n8_responder.sv
// tb_n8_responder: scoreboard bench for n8_responder against a frame-level reference model
module tb_n8_responder;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       latch = 1'b0;
    logic       pulse = 1'b0;
    logic [7:0] buttons = 8'h00;
    logic       data;
    logic [3:0] bit_idx;
    logic       frame_done;
    logic       overrun;

    n8_responder #(.SYNC_STAGES(2), .N_BITS(8)) dut (
        .clk(clk), .reset_n(reset_n), .latch(latch), .pulse(pulse), .buttons(buttons),
        .data(data), .bit_idx(bit_idx), .frame_done(frame_done), .overrun(overrun)
    );

    always #10 clk = ~clk;

    typedef struct {
        string      name;
        logic       d;
        logic [3:0] idx;
        logic       ov;
    } exp_t;

    exp_t sb_q[$];
    int   fd_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    event chk_ev;

    // reference model: frame as the host will read it, and position within it
    logic [7:0] m_frame = 8'hFF;
    int         m_pos = 0;
    bit         m_loaded = 0;
    bit         m_ovr = 0;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sb_push(input string nm);
        exp_t e;
        e.name = nm;
        e.d    = (m_loaded && m_pos < 8) ? m_frame[m_pos] : 1'b1;
        e.idx  = m_loaded ? 4'(m_pos) : 4'd0;
        e.ov   = m_ovr;
        sb_q.push_back(e);
        -> chk_ev;
    endtask

    initial forever begin
        @(chk_ev);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            vectors++;
            if (data !== e.d || bit_idx !== e.idx || frame_done !== 1'b0 || overrun !== e.ov) begin
                miscompares++;
                $display("FAIL %s: got data=%0b idx=%0d fd=%0b ov=%0b, want data=%0b idx=%0d fd=0 ov=%0b",
                         e.name, data, bit_idx, frame_done, overrun, e.d, e.idx, e.ov);
            end
        end
    end

    always @(negedge clk) if (frame_done === 1'b1) begin
        vectors++;
        if (fd_q.size() == 0) begin
            miscompares++;
            $display("FAIL frame_done_unexpected: got fd=1 idx=%0d, want fd=0", bit_idx);
        end else begin
            void'(fd_q.pop_front());
            if (data !== 1'b1 || bit_idx !== 4'd8) begin
                miscompares++;
                $display("FAIL frame_done_state: got data=%0b idx=%0d, want data=1 idx=8", data, bit_idx);
            end
        end
    end

    task automatic set_buttons_loaded(input logic [7:0] b);
        buttons = b;
        m_frame = ~b;
    endtask

    task automatic do_latch(input logic [7:0] b, input int hold);
        set_buttons_loaded(b);
        latch = 1'b1;
        m_loaded = 1; m_pos = 0; m_ovr = 0;
        cyc(hold);
        sb_push("latch_hi");
        latch = 1'b0;
        cyc(6);
        sb_push("latch_lo");
    endtask

    task automatic do_pulse(input int hold);
        buttons = 8'($urandom);
        if (m_loaded && m_pos == 7) fd_q.push_back(1);
        pulse = 1'b1;
        cyc(hold);
        if (m_loaded) begin
            if (m_pos == 8) m_ovr = 1;
            else m_pos++;
        end
        sb_push("pulse_hi");
        pulse = 1'b0;
        cyc(hold);
        sb_push("pulse_lo");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset holds everything quiet whatever the host does
        for (int i = 0; i < 4; i++) begin
            latch = i[0];
            pulse = i[1];
            cyc(3);
            sb_push("reset");
        end
        latch = 1'b0; pulse = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        cyc(6);
        sb_push("idle");
        do_pulse(6);

        // full frame: A + start
        do_latch(8'b0000_1001, 6);
        for (int i = 0; i < 8; i++) do_pulse(6);
        // overrun with two extra pulses, cleared by the next latch
        do_pulse(6);
        do_pulse(6);

        // transparent load, pulses ignored while latch held
        set_buttons_loaded(8'h00);
        latch = 1'b1;
        m_loaded = 1; m_pos = 0; m_ovr = 0;
        cyc(6);
        sb_push("transp_0");
        set_buttons_loaded(8'h01);
        cyc(6);
        sb_push("transp_1");
        pulse = 1'b1;
        cyc(6);
        sb_push("transp_pulse_hi");
        pulse = 1'b0;
        cyc(6);
        set_buttons_loaded(8'h00);
        cyc(6);
        sb_push("transp_2");
        latch = 1'b0;
        cyc(6);
        sb_push("transp_lo");

        // abort mid-frame
        do_latch(8'hFF, 6);
        for (int i = 0; i < 3; i++) do_pulse(6);
        do_latch(8'h00, 6);
        for (int i = 0; i < 8; i++) do_pulse(6);

        // simultaneous latch and pulse rise mid-frame
        do_latch(8'h5A, 6);
        for (int i = 0; i < 3; i++) do_pulse(6);
        set_buttons_loaded(8'hC3);
        latch = 1'b1;
        pulse = 1'b1;
        m_loaded = 1; m_pos = 0; m_ovr = 0;
        cyc(6);
        sb_push("simul_hi");
        pulse = 1'b0;
        cyc(6);
        latch = 1'b0;
        cyc(6);
        sb_push("simul_lo");
        for (int i = 0; i < 8; i++) do_pulse(6);

        // reset released mid-frame returns to idle
        do_latch(8'hA5, 6);
        for (int i = 0; i < 4; i++) do_pulse(6);
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        m_loaded = 0; m_pos = 0; m_ovr = 0;
        cyc(6);
        sb_push("reset_mid");
        do_pulse(6);

        // randomized frames: short (aborted), full and overrun lengths
        for (int f = 0; f < 40; f++) begin
            do_latch(8'($urandom), $urandom_range(5, 9));
            for (int p = $urandom_range(0, 11); p > 0; p--) do_pulse($urandom_range(5, 8));
        end

        cyc(10);
        vectors++;
        if (fd_q.size() != 0) begin
            miscompares++;
            $display("FAIL frame_done_missing: got %0d outstanding, want 0", fd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
